// File: rtl/addsub_serial.sv
// Multi-cycle adder/subtractor: one CHUNK-bit ripple slice with a registered carry,
// LSB chunk first, behind a start/done handshake.
module addsub_serial #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             S,
    input  logic             I,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             outc,
    output logic             overflow,
    output logic             borrow,
    output logic             err
);

    localparam int N    = WIDTH / CHUNK;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

    generate
        if ((CHUNK < 1) || (CHUNK > WIDTH) || (WIDTH % CHUNK != 0)) begin : g_bad_param
            $error("addsub_serial: WIDTH must be a non-zero multiple of CHUNK");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;       // operand B, already inverted for subtraction
    logic             b_msb_q;   // un-inverted B MSB, needed by the overflow equation
    logic             s_q;
    logic             i_q;
    logic             carry_q;
    logic [IDXW-1:0]  idx_q;
    logic [WIDTH-1:0] part_q;

    logic [CHUNK-1:0] a_ch;
    logic [CHUNK-1:0] b_ch;
    logic [CHUNK-1:0] c_sum;
    logic             c_out;
    logic [WIDTH-1:0] final_sum;
    logic             a_msb;
    logic             r_msb;
    logic             ov_next;
    logic             br_next;

    always_comb begin
        a_ch           = a_q[int'(idx_q) * CHUNK +: CHUNK];
        b_ch           = b_q[int'(idx_q) * CHUNK +: CHUNK];
        {c_out, c_sum} = {1'b0, a_ch} + {1'b0, b_ch} + (CHUNK + 1)'(carry_q);
        // Partial result with the current chunk merged in; complete on the last chunk.
        final_sum      = part_q;
        final_sum[int'(idx_q) * CHUNK +: CHUNK] = c_sum;
        a_msb          = a_q[WIDTH-1];
        r_msb          = final_sum[WIDTH-1];
        ov_next        = s_q & (i_q ? ((a_msb != b_msb_q) & (r_msb != a_msb))
                                    : ((a_msb == b_msb_q) & (r_msb != a_msb)));
        br_next        = ~s_q & i_q & ~c_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            b_msb_q  <= 1'b0;
            s_q      <= 1'b0;
            i_q      <= 1'b0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            part_q   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            outc     <= 1'b0;
            overflow <= 1'b0;
            borrow   <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_q     <= input1;
                        b_q     <= input2 ^ {WIDTH{I}};
                        b_msb_q <= input2[WIDTH-1];
                        s_q     <= S;
                        i_q     <= I;
                        carry_q <= I;
                        idx_q   <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    part_q  <= final_sum;
                    carry_q <= c_out;
                    idx_q   <= idx_q + 1'b1;
                    if (idx_q == LAST) begin
                        sum      <= final_sum;
                        outc     <= c_out;
                        overflow <= ov_next;
                        borrow   <= br_next;
                        err      <= ov_next | br_next;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_serial.sv
// Bench for addsub_serial: 16-bit instances at CHUNK 1..16 plus a 32/8 instance,
// directed table, handshake corner cases and a random sweep against a reference.
module tb_addsub_serial;

    localparam int NV = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        S, I;
    logic [15:0] input1, input2;

    logic        start_v [NV];
    logic        busy_v  [NV];
    logic        done_v  [NV];
    logic [15:0] sum_v   [NV];
    logic        outc_v  [NV];
    logic        ov_v    [NV];
    logic        br_v    [NV];
    logic        err_v   [NV];

    logic        start32;
    logic [31:0] a32, b32, sum32;
    logic        busy32, done32, outc32, ov32, br32, err32;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < NV; g++) begin : g_dut
            addsub_serial #(.WIDTH(16), .CHUNK(1 << g)) u_dut (
                .clk     (clk),
                .rst_n   (rst_n),
                .start   (start_v[g]),
                .S       (S),
                .I       (I),
                .input1  (input1),
                .input2  (input2),
                .busy    (busy_v[g]),
                .done    (done_v[g]),
                .sum     (sum_v[g]),
                .outc    (outc_v[g]),
                .overflow(ov_v[g]),
                .borrow  (br_v[g]),
                .err     (err_v[g])
            );
        end
    endgenerate

    addsub_serial #(.WIDTH(32), .CHUNK(8)) u_dut32 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start32),
        .S       (S),
        .I       (I),
        .input1  (a32),
        .input2  (b32),
        .busy    (busy32),
        .done    (done32),
        .sum     (sum32),
        .outc    (outc32),
        .overflow(ov32),
        .borrow  (br32),
        .err     (err32)
    );

    typedef struct {
        logic        s;
        logic        i;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] sum;
        logic [3:0]  fl;    // {outc, overflow, borrow, err}
        string       name;
    } vec_t;

    vec_t tab [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [19:0] model(input logic s, input logic i,
                                          input logic [15:0] a, input logic [15:0] b);
        logic [16:0] f;
        logic        r, ov, br;
        f  = {1'b0, a} + {1'b0, b ^ {16{i}}} + 17'(i);
        r  = f[15];
        ov = s & (i ? ((a[15] != b[15]) && (r != a[15])) : ((a[15] == b[15]) && (r != a[15])));
        br = ~s & i & ~f[16];
        return {f[15:0], f[16], ov, br, ov | br};
    endfunction

    // Drives one start edge; returns #1 after it with the inputs scrambled.
    task automatic launch(input int k, input logic s, input logic i,
                          input logic [15:0] a, input logic [15:0] b);
        S = s; I = i; input1 = a; input2 = b;
        start_v[k] = 1'b1;
        @(posedge clk); #1;
        start_v[k] = 1'b0;
        chk("busy_after_start", 32'(busy_v[k]), 32'd1);
        S = 1'($urandom); I = 1'($urandom);
        input1 = 16'($urandom); input2 = 16'($urandom);
    endtask

    task automatic wait_done(input int k, input int pre, input string name,
                             input logic [15:0] esum, input logic [3:0] efl);
        int cyc = pre;
        while (!done_v[k] && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({name, "_latency"}, 32'(cyc), 32'(16 >> k));
        chk({name, "_sum"}, 32'(sum_v[k]), 32'(esum));
        chk({name, "_flags"}, 32'({outc_v[k], ov_v[k], br_v[k], err_v[k]}), 32'(efl));
    endtask

    task automatic count_done(input int k, input int ncyc, output int pulses);
        pulses = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #1;
            if (done_v[k]) pulses++;
        end
    endtask

    initial begin
        int          pulses;
        int          cyc;
        logic [19:0] m;
        logic        rs, ri;
        logic [15:0] ra, rb;

        tab[0]  = '{1'b0, 1'b0, 16'h1234, 16'h0FCD, 16'h2201, 4'b0000, "uadd"};
        tab[1]  = '{1'b0, 1'b1, 16'h0005, 16'h0007, 16'hFFFE, 4'b0011, "usub_neg"};
        tab[2]  = '{1'b0, 1'b1, 16'h0007, 16'h0005, 16'h0002, 4'b1000, "usub_pos"};
        tab[3]  = '{1'b1, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101, "sadd_ov"};
        tab[4]  = '{1'b1, 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 4'b1101, "ssub_ov"};
        tab[5]  = '{1'b1, 1'b1, 16'h0003, 16'h0005, 16'hFFFE, 4'b0000, "ssub_neg"};
        tab[6]  = '{1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 4'b1000, "uadd_wrap"};
        tab[7]  = '{1'b1, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 4'b1000, "sadd_m1p1"};
        tab[8]  = '{1'b1, 1'b0, 16'h8000, 16'h8000, 16'h0000, 4'b1101, "sadd_negov"};
        tab[9]  = '{1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 4'b1000, "usub_zero"};
        tab[10] = '{1'b1, 1'b1, 16'h1234, 16'h1234, 16'h0000, 4'b1000, "ssub_eq"};
        tab[11] = '{1'b0, 1'b1, 16'h0000, 16'h0001, 16'hFFFF, 4'b0011, "usub_under"};

        S = 1'b0; I = 1'b0; input1 = '0; input2 = '0;
        for (int k = 0; k < NV; k++) start_v[k] = 1'b0;
        start32 = 1'b0; a32 = '0; b32 = '0;

        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < NV; k++)
            chk("reset_state", 32'({busy_v[k], done_v[k], sum_v[k], outc_v[k], ov_v[k],
                                    br_v[k], err_v[k]}), 32'd0);
        chk("reset_state32", {busy32, done32, outc32, ov32, br32, err32} == 6'd0 ? sum32 : 32'hDEAD,
            32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table on every CHUNK; consecutive entries start in the done cycle.
        for (int k = 0; k < NV; k++) begin
            for (int v = 0; v < 12; v++) begin
                launch(k, tab[v].s, tab[v].i, tab[v].a, tab[v].b);
                wait_done(k, 0, tab[v].name, tab[v].sum, tab[v].fl);
            end
            @(posedge clk); #1;
            chk("done_single_pulse", 32'(done_v[k]), 32'd0);
            chk("sum_hold", 32'(sum_v[k]), 32'(tab[11].sum));
        end

        // start re-pulsed with new operands while busy: ignored.
        launch(2, 1'b0, 1'b0, 16'h1234, 16'h0FCD);
        start_v[2] = 1'b1; S = 1'b1; I = 1'b1; input1 = 16'hFFFF; input2 = 16'hFFFF;
        @(posedge clk); #1;
        start_v[2] = 1'b0;
        wait_done(2, 1, "busy_restart", 16'h2201, 4'b0000);
        count_done(2, 8, pulses);
        chk("busy_restart_no_extra_done", 32'(pulses), 32'd0);
        chk("busy_restart_hold", 32'(sum_v[2]), 32'h2201);

        // Reset during RUN aborts the operation.
        launch(2, 1'b0, 1'b1, 16'h0005, 16'h0007);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", 32'({busy_v[2], done_v[2], sum_v[2], outc_v[2], ov_v[2],
                                  br_v[2], err_v[2]}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        count_done(2, 8, pulses);
        chk("abort_no_done", 32'(pulses), 32'd0);
        launch(2, tab[0].s, tab[0].i, tab[0].a, tab[0].b);
        wait_done(2, 0, "after_abort", tab[0].sum, tab[0].fl);

        // WIDTH=32, CHUNK=8 signed overflow.
        S = 1'b1; I = 1'b0; a32 = 32'h7FFF_FFFF; b32 = 32'h0000_0001; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0; a32 = '0; b32 = '0;
        cyc = 0;
        while (!done32 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("w32_latency", 32'(cyc), 32'd4);
        chk("w32_sum", sum32, 32'h8000_0000);
        chk("w32_flags", 32'({outc32, ov32, br32, err32}), 32'b0101);

        // Random sweep against the reference model.
        for (int k = 0; k < NV; k++) begin
            for (int n = 0; n < 200; n++) begin
                rs = 1'($urandom); ri = 1'($urandom);
                ra = 16'($urandom); rb = 16'($urandom);
                if (n % 8 == 0) ra = {ra[15], 15'h7FFF};
                m = model(rs, ri, ra, rb);
                launch(k, rs, ri, ra, rb);
                wait_done(k, 0, "rand", m[19:4], m[3:0]);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
